systolic_weight_sched: RTL

//  Sequences one job on the ARRAY_ROWS x ARRAY_COLS DSP-free systolic PE array.

---
 rtl/systolic_weight_sched.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_weight_sched.sv
`default_nettype none
// ============================================================================
// Module   : systolic_weight_sched
// Function : Job sequencer for the systolic PE array. Streams weight tiles
//            row by row into ping-pong weight banks and gates the activation
//            stream while a full bank computes, so tile n+1 loads while
//            tile n computes.
// Revision : 1.0  initial release
// ============================================================================
module systolic_weight_sched #(
    parameter int ARRAY_ROWS   = 16,
    parameter int ARRAY_COLS   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACT_WIDTH    = 8,
    parameter int DRAIN_LAT    = 34
) (
    input  logic                               s_clk,
    input  logic                               s_rst_n,
    input  logic                               start,
    input  logic [15:0]                        cfg_tile_num,
    input  logic [15:0]                        cfg_act_len,
    output logic                               busy,
    output logic                               done,
    input  logic                               s_wgt_valid,
    output logic                               s_wgt_ready,
    input  logic [ARRAY_COLS*WEIGHT_WIDTH-1:0] s_wgt_data,
    output logic [ARRAY_ROWS-1:0]              weight_row_vld,
    output logic [ARRAY_COLS*WEIGHT_WIDTH-1:0] weights,
    output logic                               weight_LoadPtr,
    output logic                               weight_CalcPtr,
    input  logic                               s_act_valid,
    output logic                               s_act_ready,
    output logic                               act_issue,
    output logic                               tile_last
);

    localparam int                DATA_W     = ARRAY_COLS * WEIGHT_WIDTH;
    localparam int                ROW_W      = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ARRAY_ROWS - 1);
    localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_LAT - 1);
    // An array whose drain window is shorter than its wavefront, or an odd
    // activation width, cannot be sequenced safely: such a build never starts.
    localparam bit                PARAMS_OK  = (DRAIN_LAT >= ARRAY_ROWS + ARRAY_COLS + 2)
                                               && ((ACT_WIDTH % 2) == 0);

    typedef enum logic [0:0] {
        L_IDLE = 1'b0,
        L_LOAD = 1'b1
    } lstate_e;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RUN   = 2'd1,
        C_DRAIN = 2'd2
    } cstate_e;

    lstate_e             lstate_q, lstate_d;
    cstate_e             cstate_q, cstate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         tile_num_q, tile_num_d;
    logic [15:0]         act_len_q, act_len_d;
    logic [15:0]         tiles_loaded_q, tiles_loaded_d;
    logic [15:0]         tiles_done_q, tiles_done_d;
    logic [15:0]         act_cnt_q, act_cnt_d;
    logic [15:0]         drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                load_ptr_q, load_ptr_d;
    logic                ptr_flip_q, ptr_flip_d;
    logic                calc_ptr_q, calc_ptr_d;
    logic [ARRAY_ROWS-1:0] row_vld_q, row_vld_d;
    logic [DATA_W-1:0]   weights_q, weights_d;

    logic                w_wgt_fire;
    logic                w_act_fire;
    logic                w_last_row;
    logic                w_last_act;
    logic [15:0]         w_tiles_done_inc;

    assign w_wgt_fire       = s_wgt_valid && (lstate_q == L_LOAD);
    assign w_act_fire       = s_act_valid && (cstate_q == C_RUN);
    assign w_last_row       = (row_cnt_q == LAST_ROW);
    assign w_last_act       = (act_cnt_q == (act_len_q - 16'd1));
    assign w_tiles_done_inc = tiles_done_q + 16'd1;

    // Job control, loader FSM and compute FSM next-state logic.
    always_comb begin
        lstate_d       = lstate_q;
        cstate_d       = cstate_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        tile_num_d     = tile_num_q;
        act_len_d      = act_len_q;
        tiles_loaded_d = tiles_loaded_q;
        tiles_done_d   = tiles_done_q;
        act_cnt_d      = act_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        row_cnt_d      = row_cnt_q;
        bank_full_d    = bank_full_q;
        load_ptr_d     = load_ptr_q;
        ptr_flip_d     = 1'b0;
        calc_ptr_d     = calc_ptr_q;
        row_vld_d      = '0;
        weights_d      = weights_q;

        // Job start: an empty job completes immediately without going busy.
        if (start && !busy_q && PARAMS_OK) begin
            tile_num_d     = cfg_tile_num;
            act_len_d      = cfg_act_len;
            tiles_loaded_d = 16'd0;
            tiles_done_d   = 16'd0;
            act_cnt_d      = 16'd0;
            row_cnt_d      = '0;
            if ((cfg_tile_num == 16'd0) || (cfg_act_len == 16'd0)) begin
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end

        // The load pointer moves one cycle after the last row strobe, so the
        // PEs see the final strobe of a tile paired with its own bank.
        if (ptr_flip_q) begin
            load_ptr_d = ~load_ptr_q;
        end

        unique case (lstate_q)
            L_IDLE: begin
                if (busy_q && !ptr_flip_q && (tiles_loaded_q < tile_num_q)
                        && !bank_full_q[load_ptr_q]) begin
                    lstate_d = L_LOAD;
                end
            end
            L_LOAD: begin
                if (w_wgt_fire) begin
                    weights_d = s_wgt_data;
                    row_vld_d = ARRAY_ROWS'(1) << row_cnt_q;
                    if (w_last_row) begin
                        row_cnt_d               = '0;
                        bank_full_d[load_ptr_q] = 1'b1;
                        ptr_flip_d              = 1'b1;
                        tiles_loaded_d          = tiles_loaded_q + 16'd1;
                        lstate_d                = L_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            default: lstate_d = L_IDLE;
        endcase

        // Loader and compute always address opposite banks, so the set above
        // and the clear below never collide.
        unique case (cstate_q)
            C_IDLE: begin
                if (busy_q && bank_full_q[calc_ptr_q]) begin
                    cstate_d = C_RUN;
                end
            end
            C_RUN: begin
                if (w_act_fire) begin
                    if (w_last_act) begin
                        act_cnt_d   = 16'd0;
                        drain_cnt_d = 16'd0;
                        cstate_d    = C_DRAIN;
                    end else begin
                        act_cnt_d = act_cnt_q + 16'd1;
                    end
                end
            end
            C_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    bank_full_d[calc_ptr_q] = 1'b0;
                    calc_ptr_d              = ~calc_ptr_q;
                    tiles_done_d            = w_tiles_done_inc;
                    drain_cnt_d             = 16'd0;
                    cstate_d                = C_IDLE;
                    if (w_tiles_done_inc == tile_num_q) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial tile.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            lstate_q       <= L_IDLE;
            cstate_q       <= C_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            tile_num_q     <= 16'd0;
            act_len_q      <= 16'd0;
            tiles_loaded_q <= 16'd0;
            tiles_done_q   <= 16'd0;
            act_cnt_q      <= 16'd0;
            drain_cnt_q    <= 16'd0;
            row_cnt_q      <= '0;
            bank_full_q    <= 2'b00;
            load_ptr_q     <= 1'b0;
            ptr_flip_q     <= 1'b0;
            calc_ptr_q     <= 1'b0;
            row_vld_q      <= '0;
            weights_q      <= '0;
        end else begin
            lstate_q       <= lstate_d;
            cstate_q       <= cstate_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            tile_num_q     <= tile_num_d;
            act_len_q      <= act_len_d;
            tiles_loaded_q <= tiles_loaded_d;
            tiles_done_q   <= tiles_done_d;
            act_cnt_q      <= act_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            row_cnt_q      <= row_cnt_d;
            bank_full_q    <= bank_full_d;
            load_ptr_q     <= load_ptr_d;
            ptr_flip_q     <= ptr_flip_d;
            calc_ptr_q     <= calc_ptr_d;
            row_vld_q      <= row_vld_d;
            weights_q      <= weights_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign s_wgt_ready    = (lstate_q == L_LOAD);
    assign weight_row_vld = row_vld_q;
    assign weights        = weights_q;
    assign weight_LoadPtr = load_ptr_q;
    assign weight_CalcPtr = calc_ptr_q;
    assign s_act_ready    = (cstate_q == C_RUN);
    assign act_issue      = w_act_fire;
    assign tile_last      = w_act_fire && w_last_act;

endmodule
`default_nettype wire
